// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the board-input blocks: debounce FSM state
// encodings and the default stable-sample count / counter width.
package btn_debounce_pkg;

  // 10 ms at 50 MHz
  localparam int CNT_MAX_DEF = 500000;
  localparam int CNT_W_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/btn_debounce.sv
// Push-button / slide-switch debouncer: synchronizes btn_in, then requires
// CNT_MAX consecutive stable samples before accepting a new level. Emits
// one-cycle registered rise/fall pulses aligned with the level change.
// Build option: BTN_ACTIVE_LOW_EN inverts btn_in ahead of the synchronizer
// for pull-up buttons; outputs always use 1 = pressed.
//
// state   | meaning
// IDLE_LO | level 0, waiting for a high sample
// WAIT_HI | candidate 1, counting stable high samples
// IDLE_HI | level 1, waiting for a low sample
// WAIT_LO | candidate 0, counting stable low samples
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             btn_raw;
  logic             s2;
  btn_state_t       state;
  btn_state_t       nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             level_q;
  logic             nxt_level;
  logic             rise_q;
  logic             nxt_rise;
  logic             fall_q;
  logic             nxt_fall;

`ifdef BTN_ACTIVE_LOW_EN
  // Inverting before s1 keeps the synchronizer reset value meaning "released".
  assign btn_raw = ~btn_in;
`else
  assign btn_raw = btn_in;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (s2)
  );

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE_LO;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      level_q <= nxt_level;
      rise_q  <= nxt_rise;
      fall_q  <= nxt_fall;
    end
  end

  // Next-state logic; any disagreeing sample while waiting drops back to idle.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_level = level_q;
    nxt_rise  = 1'b0;
    nxt_fall  = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s2) begin
          nxt_state = WAIT_HI;
          nxt_cnt   = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          nxt_state = IDLE_LO;
          nxt_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nxt_state = IDLE_HI;
          nxt_cnt   = '0;
          nxt_level = 1'b1;
          nxt_rise  = 1'b1;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s2) begin
          nxt_state = WAIT_LO;
          nxt_cnt   = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          nxt_state = IDLE_HI;
          nxt_cnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nxt_state = IDLE_LO;
          nxt_cnt   = '0;
          nxt_level = 1'b0;
          nxt_fall  = 1'b1;
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = IDLE_LO;
        nxt_cnt   = '0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with CNT_MAX=4: stimulus pushes the
// expected pulse (kind and edge number), a monitor pops on each pulse.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

`ifdef BTN_ACTIVE_LOW_EN
  localparam bit ACT_LO = 1'b1;
`else
  localparam bit ACT_LO = 1'b0;
`endif

  btn_debounce #(.CNT_MAX(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit is_rise;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mdl_level = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit pressed);
    btn_in = pressed ^ ACT_LO;
  endtask

  task automatic expect_ev(input bit is_rise, input int at);
    exp_t e;
    e.is_rise = is_rise;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk(e.is_rise ? "rise_missing" : "fall_missing", 0, 1);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) mdl_level = exp_q[0].is_rise;
      chk("level", int'(btn_level), int'(mdl_level));
      chk("rise_fall_excl", int'(btn_rise & btn_fall), 0);
      if (btn_rise || btn_fall) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", int'(btn_rise), int'(e.is_rise));
          chk("pulse_edge", cyc, e.cyc);
          chk("pulse_level", int'(btn_level), int'(e.is_rise));
        end
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_level"}, int'(btn_level), 0);
    chk({tag, "_rise"}, int'(btn_rise), 0);
    chk({tag, "_fall"}, int'(btn_fall), 0);
  endtask

  task automatic stimulus();
    // power-on reset
    drive(1'b0);
    rst_n = 1'b0;
    step(3);
    check_cleared("por");
    rst_n = 1'b1;

    // clean press and release
    step(2);
    drive(1'b1);
    expect_ev(1'b1, cyc + 7);
    step(12);
    drive(1'b0);
    expect_ev(1'b0, cyc + 7);
    step(12);

    // bouncing press, final transition is 0->1
    drive(1'b1); step(1);
    drive(1'b0); step(1);
    drive(1'b1); step(1);
    drive(1'b0); step(1);
    drive(1'b1);
    expect_ev(1'b1, cyc + 7);
    step(12);
    drive(1'b0);
    expect_ev(1'b0, cyc + 7);
    step(12);

    // 4-cycle glitch rejected
    drive(1'b1);
    step(4);
    drive(1'b0);
    step(12);

    // 5-cycle pulse accepted, then released
    drive(1'b1);
    expect_ev(1'b1, cyc + 7);
    step(5);
    drive(1'b0);
    expect_ev(1'b0, cyc + 12 - 5);
    step(14);

    // alternating every cycle never settles
    for (int i = 0; i < 20; i++) begin
      drive(i % 2 == 0);
      step(1);
    end
    drive(1'b0);
    step(12);

    // reset mid-count, button held through release
    drive(1'b1);
    step(5);
    #1 rst_n = 1'b0;
    #1 check_cleared("rst_midcount");
    step(2);
    rst_n = 1'b1;
    expect_ev(1'b1, cyc + 7);
    step(12);

    // reset while pressed: level clears at once, no fall pulse
    #2 rst_n = 1'b0;
    mdl_level = 1'b0;
    #1 check_cleared("rst_pressed");
    step(2);
    drive(1'b0);
    step(2);
    rst_n = 1'b1;
    step(12);

    chk("pending_events", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
